// File: rtl/bram_portb_arbiter.sv
// Port-B arbiter: host write FIFO plus engine req/gnt share one registered BRAM access per cycle.
// Round-robin by default; define HOST_PRIORITY_EN for strict host-over-engine priority.
module bram_portb_arbiter #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 8,
   parameter int HBUF_DEPTH = 4,
   parameter int RD_LAT     = 1
) (
   input  logic                          clk100m,
   input  logic                          rst_n,
   input  logic                          host_wr,
   input  logic [ADDR_W-1:0]             host_addr,
   input  logic [DATA_W-1:0]             host_data,
   output logic                          host_full,
   output logic [$clog2(HBUF_DEPTH):0]   host_level,
   output logic                          host_ovf,
   input  logic                          ovf_clr,
   input  logic                          eng_req,
   input  logic                          eng_we,
   input  logic [ADDR_W-1:0]             eng_addr,
   input  logic [DATA_W-1:0]             eng_wdata,
   output logic                          eng_gnt,
   output logic                          eng_rvalid,
   output logic [DATA_W-1:0]             eng_rdata,
   output logic [ADDR_W-1:0]             bram_addr,
   output logic [DATA_W-1:0]             bram_din,
   output logic                          bram_we,
   input  logic [DATA_W-1:0]             bram_dout
);
   localparam int PTR_W = $clog2(HBUF_DEPTH);
   localparam int LVL_W = PTR_W + 1;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } hentry_t;

   hentry_t          fifo_mem [HBUF_DEPTH];
   hentry_t          head;
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [LVL_W-1:0] level;
   logic             h_cand, e_cand, grant_h, grant_e;
   logic             push, pop, ovf_set;
   logic [RD_LAT:0]  rd_tag;

`ifdef HOST_PRIORITY_EN
   // Strict priority: no fairness pointer exists in this build.
`else
   logic rr_eng;

   always_ff @(posedge clk100m) begin
      if (!rst_n)       rr_eng <= 1'b1;
      else if (grant_e) rr_eng <= 1'b0;
      else if (grant_h) rr_eng <= 1'b1;
   end
`endif

   always_comb begin
      h_cand = (level != '0);
      e_cand = eng_req;
`ifdef HOST_PRIORITY_EN
      grant_h = h_cand;
      grant_e = e_cand && !h_cand;
`else
      grant_h = h_cand && (!e_cand || !rr_eng);
      grant_e = e_cand && (!h_cand ||  rr_eng);
`endif
   end

   assign host_full  = (level == LVL_W'(HBUF_DEPTH));
   assign host_level = level;
   assign head       = fifo_mem[rd_ptr];
   assign pop        = grant_h;
   // A pop in the same cycle frees a slot, so a push while full is still accepted.
   assign push       = host_wr && (!host_full || pop);
   assign ovf_set    = host_wr && host_full && !pop;
   assign eng_gnt    = grant_e;
   assign eng_rvalid = rd_tag[RD_LAT];

   // NOTE: FIFO storage is not reset; level and pointers alone decide which entries are valid.
   always_ff @(posedge clk100m) begin
      if (push) fifo_mem[wr_ptr] <= hentry_t'{addr: host_addr, data: host_data};
   end

   // NOTE: every register here uses non-blocking assignment so all of them sample pre-edge values.
   always_ff @(posedge clk100m) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         host_ovf  <= 1'b0;
         bram_addr <= '0;
         bram_din  <= '0;
         bram_we   <= 1'b0;
         rd_tag    <= '0;
         eng_rdata <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase

         if (ovf_set)      host_ovf <= 1'b1;
         else if (ovf_clr) host_ovf <= 1'b0;

         if (grant_h) begin
            bram_addr <= head.addr;
            bram_din  <= head.data;
            bram_we   <= 1'b1;
         end else if (grant_e) begin
            bram_addr <= eng_addr;
            bram_din  <= eng_wdata;
            bram_we   <= eng_we;
         end else begin
            bram_we   <= 1'b0;
         end

         // bram_addr acts as the BRAM address register; doutb follows it RD_LAT cycles after the grant edge.
         rd_tag <= {rd_tag[RD_LAT-1:0], grant_e && !eng_we};
         if (rd_tag[RD_LAT-1]) eng_rdata <= bram_dout;
      end
   end

endmodule

// File: tb/tb_bram_portb_arbiter.sv
// Directed bench for bram_portb_arbiter with a behavioural BRAM on port B.
`timescale 1ns/1ps
module tb_bram_portb_arbiter;
   localparam int ADDR_W     = 8;
   localparam int DATA_W     = 8;
   localparam int HBUF_DEPTH = 4;
   localparam int RD_LAT     = 1;

   logic                        clk100m = 1'b0;
   logic                        rst_n;
   logic                        host_wr;
   logic [ADDR_W-1:0]           host_addr;
   logic [DATA_W-1:0]           host_data;
   logic                        host_full;
   logic [$clog2(HBUF_DEPTH):0] host_level;
   logic                        host_ovf;
   logic                        ovf_clr;
   logic                        eng_req;
   logic                        eng_we;
   logic [ADDR_W-1:0]           eng_addr;
   logic [DATA_W-1:0]           eng_wdata;
   logic                        eng_gnt;
   logic                        eng_rvalid;
   logic [DATA_W-1:0]           eng_rdata;
   logic [ADDR_W-1:0]           bram_addr;
   logic [DATA_W-1:0]           bram_din;
   logic                        bram_we;
   logic [DATA_W-1:0]           bram_dout;

   logic [DATA_W-1:0] bmem [256];
   int n_vec = 0;
   int n_err = 0;

`ifdef HOST_PRIORITY_EN
   logic [4:0] exp_gnt6  = 5'b10000;
   logic [7:0] exp_addr6 [5] = '{8'h00, 8'h90, 8'h91, 8'h92, 8'h80};
`else
   logic [4:0] exp_gnt6  = 5'b00010;
   logic [7:0] exp_addr6 [5] = '{8'h00, 8'h80, 8'h90, 8'h91, 8'h92};
`endif

   always #5 clk100m = ~clk100m;

   bram_portb_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .HBUF_DEPTH(HBUF_DEPTH), .RD_LAT(RD_LAT)
   ) dut (
      .clk100m(clk100m), .rst_n(rst_n),
      .host_wr(host_wr), .host_addr(host_addr), .host_data(host_data),
      .host_full(host_full), .host_level(host_level), .host_ovf(host_ovf), .ovf_clr(ovf_clr),
      .eng_req(eng_req), .eng_we(eng_we), .eng_addr(eng_addr), .eng_wdata(eng_wdata),
      .eng_gnt(eng_gnt), .eng_rvalid(eng_rvalid), .eng_rdata(eng_rdata),
      .bram_addr(bram_addr), .bram_din(bram_din), .bram_we(bram_we), .bram_dout(bram_dout)
   );

   // BRAM model: read follows the registered bram_addr, writes land at the clock edge.
   assign bram_dout = bmem[bram_addr];

   initial begin
      for (int i = 0; i < 256; i++) bmem[i] = '0;
      bmem[8'h00] = 8'h11;
      bmem[8'h01] = 8'h22;
      bmem[8'h02] = 8'h33;
      bmem[8'h03] = 8'h44;
      bmem[8'h20] = 8'h3C;
      forever begin
         @(posedge clk100m);
         if (bram_we) bmem[bram_addr] <= bram_din;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk100m);
      #1;
   endtask

   initial begin
      logic t6_granted;
      int   exp_i;

      rst_n = 1'b0; host_wr = 1'b0; host_addr = '0; host_data = '0; ovf_clr = 1'b0;
      eng_req = 1'b0; eng_we = 1'b0; eng_addr = '0; eng_wdata = '0;
      step();
      step();
      check("rst_level",  32'(host_level), 0);
      check("rst_full",   32'(host_full),  0);
      check("rst_ovf",    32'(host_ovf),   0);
      check("rst_we",     32'(bram_we),    0);
      check("rst_addr",   32'(bram_addr),  0);
      check("rst_din",    32'(bram_din),   0);
      check("rst_rvalid", 32'(eng_rvalid), 0);
      check("rst_rdata",  32'(eng_rdata),  0);
      rst_n = 1'b1;

      // Test 1: single host write
      host_wr = 1'b1; host_addr = 8'h10; host_data = 8'hA5;
      step();
      host_wr = 1'b0;
      check("t1_level_push", 32'(host_level), 1);
      step();
      check("t1_addr",  32'(bram_addr),  32'h10);
      check("t1_din",   32'(bram_din),   32'hA5);
      check("t1_we",    32'(bram_we),    1);
      check("t1_level", 32'(host_level), 0);
      step();
      check("t1_idle_we",   32'(bram_we),   0);
      check("t1_hold_addr", 32'(bram_addr), 32'h10);
      check("t1_hold_din",  32'(bram_din),  32'hA5);

      // Test 2: engine read with RD_LAT=1
      eng_req = 1'b1; eng_we = 1'b0; eng_addr = 8'h20;
      #1;
      check("t2_gnt", 32'(eng_gnt), 1);
      step();
      eng_req = 1'b0;
      check("t2_c1_rvalid", 32'(eng_rvalid), 0);
      check("t2_c1_addr",   32'(bram_addr),  32'h20);
      check("t2_c1_we",     32'(bram_we),    0);
      step();
      check("t2_c2_rvalid", 32'(eng_rvalid), 1);
      check("t2_c2_rdata",  32'(eng_rdata),  32'h3C);
      step();
      check("t2_c3_rvalid", 32'(eng_rvalid), 0);

      // Test 3: host burst against a held engine request, overflow, clear, drain
      for (int k = 0; k < 13; k++) begin
         eng_req = (k < 9); eng_we = 1'b1; eng_addr = 8'h40; eng_wdata = 8'h77;
         host_wr = (k < 9); host_addr = 8'(8'h50 + k); host_data = 8'(8'hB0 + k);
         ovf_clr = (k == 8) || (k == 9);
         #1;
         check("t3_gnt", 32'(eng_gnt), 32'((k < 9) && (k % 2 == 0)));
         if (k == 7 || k == 8) check("t3_full", 32'(host_full), 1);
         step();
         if (k < 9 && k % 2 == 0) begin
            check("t3_eng_addr", 32'(bram_addr), 32'h40);
            check("t3_eng_din",  32'(bram_din),  32'h77);
         end else begin
            exp_i = (k < 9) ? (k / 2) : (k - 5);
            check("t3_host_addr", 32'(bram_addr), 32'(8'h50 + exp_i));
            check("t3_host_din",  32'(bram_din),  32'(8'hB0 + exp_i));
         end
         check("t3_we", 32'(bram_we), 1);
         exp_i = (k < 9) ? ((k / 2 + 1 > 4) ? 4 : k / 2 + 1) : (12 - k);
         check("t3_level", 32'(host_level), 32'(exp_i));
         check("t3_ovf",   32'(host_ovf),   32'(k == 8));
      end
      host_wr = 1'b0; eng_req = 1'b0; ovf_clr = 1'b0;
      step();
      check("t3_idle_we", 32'(bram_we), 0);

      // Test 4: four back-to-back engine reads
      for (int k = 0; k < 8; k++) begin
         eng_req = (k < 4); eng_we = 1'b0; eng_addr = 8'(k);
         #1;
         check("t4_gnt", 32'(eng_gnt), 32'(k < 4));
         step();
         check("t4_rvalid", 32'(eng_rvalid), 32'(k >= 1 && k <= 4));
         if (k >= 1 && k <= 4) check("t4_rdata", 32'(eng_rdata), 32'(8'h11 * k));
      end

      // Test 5: reset with two queued host writes and one read in flight
      host_wr = 1'b1; host_addr = 8'h60; host_data = 8'hC0;
      eng_req = 1'b1; eng_we = 1'b1; eng_addr = 8'h70; eng_wdata = 8'h5E;
      #1;
      check("t5_gnt_a", 32'(eng_gnt), 1);
      step();
      host_addr = 8'h61; host_data = 8'hC1; eng_req = 1'b0;
      #1;
      check("t5_gnt_b", 32'(eng_gnt), 0);
      step();
      host_addr = 8'h62; host_data = 8'hC2; eng_req = 1'b1; eng_we = 1'b0; eng_addr = 8'h02;
      #1;
      check("t5_gnt_c", 32'(eng_gnt), 1);
      step();
      host_wr = 1'b0; eng_req = 1'b0; rst_n = 1'b0;
      check("t5_level_pre", 32'(host_level), 2);
      step();
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check("t5_level",  32'(host_level), 0);
         check("t5_we",     32'(bram_we),    0);
         check("t5_rvalid", 32'(eng_rvalid), 0);
         step();
      end

      // Test 6: three host writes with the engine waiting
      t6_granted = 1'b0;
      for (int k = 0; k < 5; k++) begin
         host_wr = (k < 3); host_addr = 8'(8'h90 + k); host_data = 8'(8'hD0 + k);
         eng_req = (k >= 1) && !t6_granted; eng_we = 1'b1; eng_addr = 8'h80; eng_wdata = 8'h99;
         #1;
         check("t6_gnt", 32'(eng_gnt), 32'(exp_gnt6[k]));
         if (eng_gnt) t6_granted = 1'b1;
         step();
         if (k >= 1) begin
            check("t6_addr", 32'(bram_addr), 32'(exp_addr6[k]));
            check("t6_we",   32'(bram_we),   1);
         end
      end
      host_wr = 1'b0; eng_req = 1'b0;
      step();
      check("t6_level_end", 32'(host_level), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/bram_portb_arbiter.md
Name: bram_portb_arbiter

Overview:
Shares BRAM port B in the 100 MHz domain between two requesters. The first is the host write path: single-cycle write pulses, buffered in a small FIFO. The second is the local processing engine: read/write requests with a req/gnt handshake. Exactly one BRAM access is issued per cycle, with round-robin fairness, registered BRAM-side outputs and tagged read-data return. It replaces the unconditional host-override mux on port B, so host writes never corrupt an in-flight engine access and are never silently lost.

Parameters:
ADDR_W, 8, BRAM port-B address width
DATA_W, 8, BRAM data width
HBUF_DEPTH, 4, host write FIFO depth (power of 2, ≥2)
RD_LAT, 1, BRAM port-B read latency in clocks from registered address to valid doutb

Ports:
clk100m  in  1  system clock; all logic on rising edge
rst_n  in  1  synchronous active-low reset
host_wr  in  1  host write strobe; one write per high cycle
host_addr  in  ADDR_W  host write address, sampled when host_wr=1
host_data  in  DATA_W  host write data, sampled when host_wr=1
host_full  out  1  FIFO full (combinational from level)
host_level  out  $clog2(HBUF_DEPTH)+1  FIFO occupancy
host_ovf  out  1  sticky: a host write was dropped
ovf_clr  in  1  clears host_ovf
eng_req  in  1  engine access request; held until eng_gnt
eng_we  in  1  1=write, 0=read
eng_addr  in  ADDR_W  engine address
eng_wdata  in  DATA_W  engine write data
eng_gnt  out  1  combinational; request accepted at this edge
eng_rvalid  out  1  one-cycle pulse, eng_rdata valid
eng_rdata  out  DATA_W  read data (registered)
bram_addr  out  ADDR_W  to addrb (registered)
bram_din  out  DATA_W  to dinb (registered)
bram_we  out  1  to web (registered)
bram_dout  in  DATA_W  from doutb

Behaviour:
- Reset (rst_n=0 at edge): FIFO empty, host_level=0, host_ovf=0, bram_we=0, bram_addr=0, bram_din=0, eng_rvalid=0, eng_rdata=0, read pipeline cleared, rr pointer = ENGINE-first.
- Host FIFO push on host_wr. Push when full and no pop in the same cycle: write dropped, host_ovf set. Push and pop in the same cycle while full: push accepted, level unchanged.
- ovf_clr and a new overflow in the same cycle: host_ovf stays 1 (set wins).
- Candidates each cycle: H = FIFO non-empty; E = eng_req.
- Only one candidate: it wins.
- Both candidates: winner = rr pointer. After each grant, the pointer moves to the other requester.
- No candidate: bram_we=0 next cycle; bram_addr/bram_din hold their values.
- Winner H: FIFO head popped. Next cycle bram_addr/bram_din = head entry, bram_we=1.
- Winner E: eng_gnt=1 this cycle. Next cycle bram_addr=eng_addr, bram_din=eng_wdata, bram_we=eng_we.
- Engine read: a tag shifts through a 1+RD_LAT stage pipeline. eng_rvalid pulses exactly RD_LAT+1 cycles after the eng_gnt cycle, with eng_rdata = bram_dout captured in that cycle. Back-to-back reads return in grant order with no bubbles.
- Engine may change eng_addr/we/wdata only after eng_gnt. eng_req deasserted before grant is a withdrawal; no access is issued.
- Throughput: 1 access/cycle. Worst-case engine wait is 1 cycle with round-robin.
- Reset mid-operation: pending FIFO entries and in-flight read tags are discarded; no eng_rvalid after reset.
- Host entries are written in FIFO order. An engine read of an address with a pending host write returns the old value (no forwarding).

Optional Feature:
HOST_PRIORITY_EN
- Defined: H always wins over E (strict priority). The rr pointer is not implemented. The engine can starve while the FIFO is non-empty.
- Not defined: round-robin as above.

Test Plan:
1. Reset, then host_wr of (0x10,0xA5) with engine idle. Next cycle: bram_addr=0x10, bram_din=0xA5, bram_we=1; host_level returns to 0.
2. Engine read of 0x20 (BRAM holds 0x3C), RD_LAT=1. Expect eng_gnt in cycle 0, then eng_rvalid=1 with eng_rdata=0x3C in cycle 2 only.
3. Five host_wr pulses back-to-back while eng_req is held, HBUF_DEPTH=4. Expect grants to alternate E,H,E,H…. Expect host_full observed; fifth write either accepted or dropped per level, and host_ovf=1 if dropped. ovf_clr then gives host_ovf=0.
4. Engine streams 4 reads to 0..3 continuously. Expect 4 consecutive eng_rvalid pulses with data in address order.
5. Assert rst_n=0 for 1 cycle with 2 FIFO entries and 1 read in flight. Expect no bram_we=1 and no eng_rvalid afterwards; host_level=0.
6. HOST_PRIORITY_EN defined, eng_req held, host writes ×3. Expect 3 host accesses first, then eng_gnt.
